eventually_window_monitor: RTL and testbench
============================================

EVENTUALLY_WINDOW_MONITOR -- requirements
Module: eventually_window_monitor

Interface
REQ-001 The block SHALL have parameter MIN_DLY, default 2: first tick, counted from the start cycle (tick 0), at which `a` is accepted.
REQ-002 The block SHALL have parameter MAX_DLY, default 5: last accepted tick; value 0 means unbounded ($).
REQ-003 The block SHALL have parameter STRONG, default 1: 1 means a pending unbounded or partial window at `finish` fails (s_eventually); 0 means it passes (eventually).
REQ-004 The block SHALL have parameter CNT_W, default 8: width of the tick counter and of the statistics counters.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: opens an obligation; the cycle it is sampled is tick 0.
REQ-008 The block SHALL have port a, input, 1 bit: the monitored event.
REQ-009 The block SHALL have port abort, input, 1 bit: discards the pending obligation with no verdict.
REQ-010 The block SHALL have port finish, input, 1 bit: end of trace.
REQ-011 The block SHALL have port busy, output, 1 bit: an obligation is pending.
REQ-012 The block SHALL have port pass, output, 1 bit: registered one-cycle verdict pulse.
REQ-013 The block SHALL have port fail, output, 1 bit: registered one-cycle verdict pulse.
REQ-014 The block SHALL have port overrun, output, 1 bit: registered one-cycle pulse for a start dropped while busy.
REQ-015 The block SHALL have port tick, output, CNT_W bits: current tick count.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_MIN and WINDOW; busy SHALL be 1 exactly in WAIT_MIN and WINDOW.
REQ-017 In IDLE, start=1 SHALL load tick=1 and go to WAIT_MIN if MIN_DLY>1, otherwise to WINDOW.
REQ-018 If MIN_DLY=0, `a` sampled in the start cycle SHALL produce pass the next cycle and the block SHALL stay in IDLE.
REQ-019 In WAIT_MIN, tick SHALL increment each cycle, and `a` SHALL be ignored; the block SHALL enter WINDOW on the cycle tick reaches MIN_DLY.
REQ-020 In WINDOW, a=1 SHALL assert pass on the next cycle and return the block to IDLE.
REQ-021 In WINDOW, with MAX_DLY≠0, a=0 at tick=MAX_DLY SHALL assert fail on the next cycle and return the block to IDLE.
REQ-022 With MAX_DLY=0, tick SHALL saturate at all-ones and never cause a fail on its own.
REQ-023 finish=1 while busy and `a` not accepted SHALL produce fail if STRONG=1 (either state, and either bounded or unbounded window), otherwise pass, next cycle, then IDLE.
REQ-024 When a=1 in WINDOW and finish=1 arrive together, pass SHALL take priority.
REQ-025 When abort arrives together with any verdict condition, abort SHALL take priority: return to IDLE, tick=0, no pulse.
REQ-026 start=1 while busy SHALL be ignored for the obligation and SHALL pulse overrun next cycle; in IDLE, a start coinciding with abort SHALL be dropped.
REQ-027 A verdict cycle and a start in the next cycle SHALL both be honoured: back-to-back obligations carry no dead cycle.
REQ-028 pass, fail and overrun SHALL never be asserted simultaneously with each other except overrun alongside a verdict.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, tick=0, busy=0, pass=0, fail=0 and overrun=0, and clear the statistics counters, including mid-obligation, with no verdict emitted.

Configuration
REQ-030 When macro EVT_STATS_EN is defined, the block SHALL add outputs pass_cnt and fail_cnt (CNT_W bits each, saturating) that increment on each pass and fail pulse respectively.
REQ-031 When EVT_STATS_EN is undefined, these ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification (MIN_DLY=2, MAX_DLY=5 unless stated)
REQ-032 start@0 with a=1 @3 SHALL produce pass@4, with busy high for cycles 1-3.
REQ-033 start@0 with a=1 only @1 SHALL produce fail@6, with no pass.
REQ-034 start@0 with a=1 @5 SHALL produce pass@6; start@6 and a@8 SHALL then produce pass@9.
REQ-035 start@0, start@2, a@4 SHALL produce overrun@3 and pass@5.
REQ-036 With MAX_DLY=0 and STRONG=1, start@0 and finish@20 SHALL produce fail@21; the same with STRONG=0 SHALL produce pass@21.
REQ-037 start@0 with rst_n low @3 SHALL give busy=0 @3; a@4 SHALL then produce no pass; with EVT_STATS_EN, two passes and one fail SHALL give pass_cnt=2 and fail_cnt=1.

Source files
------------

// File: rtl/eventually_window_monitor.sv
// Runtime monitor for "start |-> ##[MIN_DLY:MAX_DLY] a" with weak/strong end-of-trace handling.
// Optional saturating pass/fail counters are enabled by defining EVT_STATS_EN.
module eventually_window_monitor #(
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 5,
  parameter bit STRONG  = 1'b1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a,
  input  logic             abort,
  input  logic             finish,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             overrun,
  output logic [CNT_W-1:0] tick
`ifdef EVT_STATS_EN
  ,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MIN = 2'd1,
    WINDOW   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES  = '1;
  localparam logic [CNT_W-1:0] MIN_T = CNT_W'(MIN_DLY);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_DLY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] tick_inc;

  // Saturating so an unbounded window never wraps back into a bounded-looking tick.
  assign tick_inc = (tick_q == ONES) ? tick_q : tick_q + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      overrun_q <= overrun_d;
    end
  end

  // Priority while busy: abort, then accepted a, then window timeout, then finish.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if ((MIN_DLY == 0) && a) begin
            pass_d = 1'b1;
          end else begin
            tick_d  = ONE;
            state_d = (MIN_DLY > 1) ? WAIT_MIN : WINDOW;
          end
        end
      end
      WAIT_MIN: begin
        overrun_d = start;
        if (abort) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (finish) begin
          state_d = IDLE;
          tick_d  = '0;
          if (STRONG) fail_d = 1'b1;
          else        pass_d = 1'b1;
        end else begin
          tick_d = tick_inc;
          if (tick_inc == MIN_T) state_d = WINDOW;
        end
      end
      WINDOW: begin
        overrun_d = start;
        if (abort) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (a) begin
          state_d = IDLE;
          tick_d  = '0;
          pass_d  = 1'b1;
        end else if ((MAX_DLY != 0) && (tick_q == MAX_T)) begin
          state_d = IDLE;
          tick_d  = '0;
          fail_d  = 1'b1;
        end else if (finish) begin
          state_d = IDLE;
          tick_d  = '0;
          if (STRONG) fail_d = 1'b1;
          else        pass_d = 1'b1;
        end else begin
          tick_d = tick_inc;
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    pass    = pass_q;
    fail    = fail_q;
    overrun = overrun_q;
    tick    = tick_q;
  end

`ifdef EVT_STATS_EN
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;

  // Counted from the next-state pulse so the count moves in the same cycle the pulse shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      if (pass_d && (pass_cnt_q != ONES)) pass_cnt_q <= pass_cnt_q + ONE;
      if (fail_d && (fail_cnt_q != ONES)) fail_cnt_q <= fail_cnt_q + ONE;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_eventually_window_monitor.sv
// Bench for eventually_window_monitor: three configurations share one stimulus stream,
// an age-based obligation model is compared every cycle, and directed vectors pin pulse timing.
module tb_eventually_window_monitor;

  localparam int MIN_P[3]    = '{2, 2, 0};
  localparam int MAX_P[3]    = '{5, 0, 0};
  localparam bit STRONG_P[3] = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, a = 1'b0, abort = 1'b0, finish = 1'b0;
  logic [2:0] busy_w, pass_w, fail_w, ov_w;
  logic [7:0] tick_w[3];
`ifdef EVT_STATS_EN
  logic [7:0] pcnt_w[3], fcnt_w[3];
`endif

  int checks = 0;
  int failures = 0;

  // model state
  bit pend[3];
  int age[3];
  int pc[3], fc[3];
  bit m_pass[3], m_fail[3], m_ov[3];

  logic [31:0] obs_pass[3], obs_fail[3], obs_ov[3], obs_busy[3];

  always #5 clk = ~clk;

  eventually_window_monitor #(.MIN_DLY(2), .MAX_DLY(5), .STRONG(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .abort(abort), .finish(finish),
    .busy(busy_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .overrun(ov_w[0]), .tick(tick_w[0])
`ifdef EVT_STATS_EN
    , .pass_cnt(pcnt_w[0]), .fail_cnt(fcnt_w[0])
`endif
  );

  eventually_window_monitor #(.MIN_DLY(2), .MAX_DLY(0), .STRONG(1'b1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .abort(abort), .finish(finish),
    .busy(busy_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .overrun(ov_w[1]), .tick(tick_w[1])
`ifdef EVT_STATS_EN
    , .pass_cnt(pcnt_w[1]), .fail_cnt(fcnt_w[1])
`endif
  );

  eventually_window_monitor #(.MIN_DLY(0), .MAX_DLY(0), .STRONG(1'b0), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .abort(abort), .finish(finish),
    .busy(busy_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .overrun(ov_w[2]), .tick(tick_w[2])
`ifdef EVT_STATS_EN
    , .pass_cnt(pcnt_w[2]), .fail_cnt(fcnt_w[2])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Obligation model: a pending obligation is just its age in cycles since start.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) begin
        m_pass[k] = 1'b0;
        m_fail[k] = 1'b0;
        m_ov[k]   = 1'b0;
        if (!rst_n) begin
          pend[k] = 1'b0;
          age[k]  = 0;
          pc[k]   = 0;
          fc[k]   = 0;
        end else if (!pend[k]) begin
          if (start && !abort) begin
            if (MIN_P[k] == 0 && a) m_pass[k] = 1'b1;
            else begin
              pend[k] = 1'b1;
              age[k]  = 1;
            end
          end
        end else begin
          m_ov[k] = start;
          if (abort) pend[k] = 1'b0;
          else if (age[k] >= MIN_P[k] && a) begin
            m_pass[k] = 1'b1;
            pend[k]   = 1'b0;
          end else if (MAX_P[k] != 0 && age[k] >= MAX_P[k]) begin
            m_fail[k] = 1'b1;
            pend[k]   = 1'b0;
          end else if (finish) begin
            if (STRONG_P[k]) m_fail[k] = 1'b1;
            else             m_pass[k] = 1'b1;
            pend[k] = 1'b0;
          end else if (age[k] < 255) begin
            age[k]++;
          end
        end
        if (m_pass[k] && pc[k] < 255) pc[k]++;
        if (m_fail[k] && fc[k] < 255) fc[k]++;
      end
    end
  end

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(pend[k]));
        chk($sformatf("pass[%0d]", k), 32'(pass_w[k]), 32'(m_pass[k]));
        chk($sformatf("fail[%0d]", k), 32'(fail_w[k]), 32'(m_fail[k]));
        chk($sformatf("overrun[%0d]", k), 32'(ov_w[k]), 32'(m_ov[k]));
        chk($sformatf("tick[%0d]", k), 32'(tick_w[k]), pend[k] ? 32'(age[k]) : 32'd0);
`ifdef EVT_STATS_EN
        chk($sformatf("pass_cnt[%0d]", k), 32'(pcnt_w[k]), 32'(pc[k]));
        chk($sformatf("fail_cnt[%0d]", k), 32'(fcnt_w[k]), 32'(fc[k]));
`endif
      end
    end
  end

  task automatic do_reset();
    start = 1'b0; a = 1'b0; abort = 1'b0; finish = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives cycle c from bit c of each mask and records every DUT's outputs mid-cycle.
  task automatic run(input int n, input logic [31:0] st, input logic [31:0] av,
                     input logic [31:0] ab, input logic [31:0] fn, input logic [31:0] rs);
    for (int k = 0; k < 3; k++) begin
      obs_pass[k] = '0; obs_fail[k] = '0; obs_ov[k] = '0; obs_busy[k] = '0;
    end
    for (int c = 0; c < n; c++) begin
      start = st[c]; a = av[c]; abort = ab[c]; finish = fn[c];
      if (rs[c]) rst_n = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        obs_pass[k][c] = pass_w[k];
        obs_fail[k][c] = fail_w[k];
        obs_ov[k][c]   = ov_w[k];
        obs_busy[k][c] = busy_w[k];
      end
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0; a = 1'b0; abort = 1'b0; finish = 1'b0;
  endtask

  task automatic chk_masks(input string nm, input int k, input logic [31:0] ep,
                           input logic [31:0] ef, input logic [31:0] eo, input logic [31:0] eb);
    chk({nm, "_pass"}, obs_pass[k], ep);
    chk({nm, "_fail"}, obs_fail[k], ef);
    chk({nm, "_overrun"}, obs_ov[k], eo);
    chk({nm, "_busy"}, obs_busy[k], eb);
  endtask

  initial begin
    do_reset();
    chk("reset_busy", 32'(busy_w), 32'd0);
    chk("reset_tick0", 32'(tick_w[0]), 32'd0);

    // a inside window
    run(8, 32'h1, 32'h8, 32'h0, 32'h0, 32'h0);
    chk_masks("pass_at_tick3", 0, 32'h10, 32'h0, 32'h0, 32'hE);

    // a only before MIN_DLY, then timeout
    do_reset();
    run(9, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0);
    chk_masks("early_a_timeout", 0, 32'h0, 32'h40, 32'h0, 32'h3E);

    // a at MAX_DLY, then back-to-back obligation
    do_reset();
    run(11, 32'h41, 32'h120, 32'h0, 32'h0, 32'h0);
    chk_masks("back_to_back", 0, 32'h240, 32'h0, 32'h0, 32'h1BE);

    // start while busy
    do_reset();
    run(7, 32'h5, 32'h10, 32'h0, 32'h0, 32'h0);
    chk_masks("overrun", 0, 32'h20, 32'h0, 32'h8, 32'h1E);

    // abort beats both pass and timeout at tick 5
    do_reset();
    run(9, 32'h1, 32'h20, 32'h20, 32'h0, 32'h0);
    chk_masks("abort_prio", 0, 32'h0, 32'h0, 32'h0, 32'h3E);

    // finish in WAIT_MIN fails; finish with a in WINDOW passes
    do_reset();
    run(9, 32'h9, 32'h40, 32'h0, 32'h42, 32'h0);
    chk_masks("finish", 0, 32'h80, 32'h4, 32'h0, 32'h72);

    // start with abort in IDLE is dropped
    do_reset();
    run(5, 32'h1, 32'h4, 32'h1, 32'h0, 32'h0);
    chk_masks("start_abort", 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // unbounded window closed by finish: strong fails, weak passes
    do_reset();
    run(23, 32'h1, 32'h0, 32'h0, 32'h100000, 32'h0);
    chk_masks("unbounded_strong", 1, 32'h0, 32'h200000, 32'h0, 32'h1FFFFE);
    chk_masks("unbounded_weak", 2, 32'h200000, 32'h0, 32'h0, 32'h1FFFFE);

    // MIN_DLY=0 accepts a in the start cycle
    do_reset();
    run(8, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0);
    chk_masks("min0_immediate", 2, 32'h2, 32'h0, 32'h0, 32'h0);
    chk_masks("min2_ignores_tick0", 0, 32'h0, 32'h40, 32'h0, 32'h3E);

    // reset mid-obligation
    do_reset();
    run(7, 32'h1, 32'h10, 32'h0, 32'h0, 32'h8);
    chk_masks("mid_reset", 0, 32'h0, 32'h0, 32'h0, 32'h6);

    // two passes and one fail
    do_reset();
    run(15, 32'h91, 32'h48, 32'h0, 32'h0, 32'h0);
    chk_masks("stats_seq", 0, 32'h90, 32'h2000, 32'h0, 32'h1F6E);
`ifdef EVT_STATS_EN
    chk("pass_cnt_lit", 32'(pcnt_w[0]), 32'd2);
    chk("fail_cnt_lit", 32'(fcnt_w[0]), 32'd1);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
